// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and constants for the Keccak message padder
// Purpose: padding-mode and FSM state enums, suffix-byte constants, suffix lookup.
// Ports: none (package).
package keccak_pkg;

  typedef enum logic [1:0] {
    PAD_KECCAK = 2'd0,
    PAD_SHA3   = 2'd1,
    PAD_SHAKE  = 2'd2
  } pad_mode_e;

  localparam logic [7:0] SUFFIX_KECCAK = 8'h01;
  localparam logic [7:0] SUFFIX_SHA3   = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE  = 8'h1F;

  // Closing bit of the pad10*1 rule, lands in the last byte of the block.
  localparam logic [7:0] PAD_FINAL_BIT = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [7:0] suffix_of(input pad_mode_e mode);
    case (mode)
      PAD_SHA3:  return SUFFIX_SHA3;
      PAD_SHAKE: return SUFFIX_SHAKE;
      default:   return SUFFIX_KECCAK;
    endcase
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// rtl/keccak_pad_word.sv - builds the padded final message word
// Purpose: keeps the first byte_num bytes (MSB first), inserts the suffix byte
//          after them, zeroes the rest, and ORs 0x80 into the LSB byte when the
//          word occupies the last slot of the block.
// Ports: in (raw word), byte_num (valid bytes), is_final_slot, mode -> out.
module keccak_pad_word
  import keccak_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int BN_W = $clog2(IN_W / 8)
) (
  input  logic [IN_W-1:0] in,
  input  logic [BN_W-1:0] byte_num,
  input  logic            is_final_slot,
  input  pad_mode_e       mode,
  output logic [IN_W-1:0] out
);

  localparam int NB = IN_W / 8;

  always_comb begin
    out = '0;
    // Byte 0 sits in the MSBs, so byte b occupies bits [IN_W-1-8b -: 8].
    for (int b = 0; b < NB; b++) begin
      if (b < int'(byte_num)) begin
        out[IN_W-1-8*b -: 8] = in[IN_W-1-8*b -: 8];
      end else if (b == int'(byte_num)) begin
        out[IN_W-1-8*b -: 8] = suffix_of(mode);
      end
    end
    // Suffix and final bit may share the LSB byte (e.g. 0x81 for Keccak).
    if (is_final_slot) begin
      out[7:0] = out[7:0] | PAD_FINAL_BIT;
    end
  end

endmodule

// File: rtl/keccak_padder_param.sv
// rtl/keccak_padder_param.sv - parametrised Keccak/SHA-3/SHAKE message padder
// Purpose: packs IN_W-bit big-endian words into a RATE-bit block, applies the
//          domain suffix and final 0x80 bit, and hands the block to the
//          permutation over an out_ready/f_ack handshake.
// Ports: clk, reset_n (async, active low), clear (sync restart),
//        in/in_ready/is_last/byte_num (message word input),
//        buffer_full (input back-pressure),
//        out/out_ready/last_block (block output), f_ack (block consumed).
module keccak_padder_param
  import keccak_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int RATE     = 576,
  parameter int PAD_MODE = 0,
  localparam int BN_W    = $clog2(IN_W / 8)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic [IN_W-1:0] in,
  input  logic            in_ready,
  input  logic            is_last,
  input  logic [BN_W-1:0] byte_num,
  output logic            buffer_full,
  output logic [RATE-1:0] out,
  output logic            out_ready,
  input  logic            f_ack,
  output logic            last_block
);

  localparam int WORDS = RATE / IN_W;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);
  localparam pad_mode_e MODE = pad_mode_e'(2'(PAD_MODE));

  state_e            state_q, state_d;
  logic [RATE-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              padded_q, padded_d;

  logic              is_final_slot;
  logic [IN_W-1:0]   pad_word;
  logic [IN_W-1:0]   fill_word;

  // The next word written lands in the last slot of the block.
  assign is_final_slot = (cnt_q == LAST_SLOT);

  // Zero filler during PAD; the filler that closes the block carries 0x80.
  assign fill_word = is_final_slot ? {{(IN_W-8){1'b0}}, PAD_FINAL_BIT} : '0;

  keccak_pad_word #(
    .IN_W (IN_W),
    .BN_W (BN_W)
  ) u_pad_word (
    .in            (in),
    .byte_num      (byte_num),
    .is_final_slot (is_final_slot),
    .mode          (MODE),
    .out           (pad_word)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FILL;
      buf_q    <= '0;
      cnt_q    <= '0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      padded_q <= padded_d;
    end
  end

  // Next-state logic. Words shift in at the bottom, so after WORDS writes the
  // first word of the block sits in the MSBs of the buffer.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    padded_d = padded_q;
    if (clear) begin
      state_d  = ST_FILL;
      buf_d    = '0;
      cnt_d    = '0;
      padded_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_ready) begin
            cnt_d = cnt_q + 1'b1;
            if (is_last) begin
              buf_d    = {buf_q[RATE-IN_W-1:0], pad_word};
              padded_d = 1'b1;
              state_d  = is_final_slot ? ST_FULL : ST_PAD;
            end else begin
              buf_d = {buf_q[RATE-IN_W-1:0], in};
              if (is_final_slot) begin
                state_d = ST_FULL;
              end
            end
          end
        end
        ST_PAD: begin
          buf_d = {buf_q[RATE-IN_W-1:0], fill_word};
          cnt_d = cnt_q + 1'b1;
          if (is_final_slot) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (f_ack) begin
            buf_d    = '0;
            cnt_d    = '0;
            padded_d = 1'b0;
            state_d  = padded_q ? ST_DONE : ST_FILL;
          end
        end
        default: begin
          // DONE: hold until clear or reset
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    buffer_full = 1'b1;
    out_ready   = 1'b0;
    last_block  = 1'b0;
    case (state_q)
      ST_FILL: buffer_full = 1'b0;
      ST_FULL: begin
        out_ready  = 1'b1;
        last_block = padded_q;
      end
      default: begin
      end
    endcase
  end

  assign out = buf_q;

endmodule

// File: tb/tb_keccak_padder_param.sv
// tb/tb_keccak_padder_param.sv - directed self-checking bench for keccak_padder_param
`timescale 1ns/1ps
module tb_keccak_padder_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic         clr32, rdy32, last32, ack32;
  logic [31:0]  in32;
  logic [1:0]   bn32;
  logic         bf32, ordy32, lb32;
  logic [575:0] out32;

  logic          clr64, rdy64, last64, ack64;
  logic [63:0]   in64;
  logic [2:0]    bn64;
  logic          bf64, ordy64, lb64;
  logic [1087:0] out64;

  keccak_padder_param #(.IN_W(32), .RATE(576), .PAD_MODE(0)) dut32 (
    .clk(clk), .reset_n(reset_n), .clear(clr32), .in(in32), .in_ready(rdy32),
    .is_last(last32), .byte_num(bn32), .buffer_full(bf32), .out(out32),
    .out_ready(ordy32), .f_ack(ack32), .last_block(lb32)
  );

  keccak_padder_param #(.IN_W(64), .RATE(1088), .PAD_MODE(1)) dut64 (
    .clk(clk), .reset_n(reset_n), .clear(clr64), .in(in64), .in_ready(rdy64),
    .is_last(last64), .byte_num(bn64), .buffer_full(bf64), .out(out64),
    .out_ready(ordy64), .f_ack(ack64), .last_block(lb64)
  );

  int checks = 0;
  int failures = 0;

  // Byte-stream model: message bytes collected per block, padded by rule.
  typedef struct { logic [1087:0] blk; bit last; } exp_t;
  exp_t       e32[$];
  exp_t       e64[$];
  logic [7:0] mbuf [2][136];
  int         mcnt [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cmp_blk(input string name, input logic [1087:0] act, input logic [1087:0] req,
                         input int nchunk);
    checks++;
    if (act !== req) begin
      int idx = 0;
      failures++;
      for (int i = 0; i < nchunk; i++) if (act[64*i +: 64] !== req[64*i +: 64]) idx = i;
      $display("FAIL %s: chunk %0d got %h expected %h", name, nchunk-1-idx,
               act[64*idx +: 64], req[64*idx +: 64]);
    end
  endtask

  task automatic model_reset(input int id);
    mcnt[id] = 0;
    if (id == 0) e32.delete(); else e64.delete();
  endtask

  task automatic model_push(input int id, input bit last, input int rb);
    exp_t e;
    e.blk = '0;
    for (int i = 0; i < rb; i++) e.blk[(rb-1-i)*8 +: 8] = mbuf[id][i];
    e.last = last;
    if (id == 0) e32.push_back(e); else e64.push_back(e);
    mcnt[id] = 0;
  endtask

  task automatic model_add(input int id, input logic [63:0] w, input int wb, input bit last,
                           input int bn, input int rb, input logic [7:0] sfx);
    int n;
    n = last ? bn : wb;
    for (int k = 0; k < n; k++) begin
      mbuf[id][mcnt[id]] = w[(wb-1-k)*8 +: 8];
      mcnt[id]++;
    end
    if (last) begin
      mbuf[id][mcnt[id]] = sfx;
      mcnt[id]++;
      while (mcnt[id] < rb) begin
        mbuf[id][mcnt[id]] = 8'h00;
        mcnt[id]++;
      end
      mbuf[id][rb-1] = mbuf[id][rb-1] | 8'h80;
      model_push(id, 1'b1, rb);
    end else if (mcnt[id] == rb) begin
      model_push(id, 1'b0, rb);
    end
  endtask

  // Compare process: every cycle a block is presented it must match the model.
  always @(negedge clk) begin
    if (reset_n && ordy32) begin
      if (e32.size() == 0) begin
        checks++; failures++;
        $display("FAIL blk32: out_ready got 1 expected 0");
      end else begin
        cmp_blk("blk32", {512'b0, out32}, e32[0].blk, 9);
        chk("last32", {63'b0, lb32}, {63'b0, e32[0].last});
        if (ack32 && !clr32) e32.delete(0);
      end
    end
    if (reset_n && ordy64) begin
      if (e64.size() == 0) begin
        checks++; failures++;
        $display("FAIL blk64: out_ready got 1 expected 0");
      end else begin
        cmp_blk("blk64", out64, e64[0].blk, 17);
        chk("last64", {63'b0, lb64}, {63'b0, e64[0].last});
        if (ack64 && !clr64) e64.delete(0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [31:0] w, input bit last, input logic [1:0] bn);
    if (!bf32) model_add(0, {32'b0, w}, 4, last, int'(bn), 72, 8'h01);
    in32 = w; rdy32 = 1'b1; last32 = last; bn32 = bn;
    cyc();
    rdy32 = 1'b0; last32 = 1'b0; bn32 = '0;
  endtask

  task automatic send64(input logic [63:0] w, input bit last, input logic [2:0] bn);
    if (!bf64) model_add(1, w, 8, last, int'(bn), 136, 8'h06);
    in64 = w; rdy64 = 1'b1; last64 = last; bn64 = bn;
    cyc();
    rdy64 = 1'b0; last64 = 1'b0; bn64 = '0;
  endtask

  task automatic wait32(output int n);
    n = 0;
    while (!ordy32 && n < 300) begin cyc(); n++; end
    chk("ready32_timeout", {63'b0, ordy32}, 64'd1);
  endtask

  task automatic wait64(output int n);
    n = 0;
    while (!ordy64 && n < 300) begin cyc(); n++; end
    chk("ready64_timeout", {63'b0, ordy64}, 64'd1);
  endtask

  task automatic ack32_pulse();
    ack32 = 1'b1; cyc(); ack32 = 1'b0;
  endtask

  task automatic clear32();
    clr32 = 1'b1; cyc(); clr32 = 1'b0; model_reset(0);
  endtask

  function automatic logic [31:0] w32(input int i);
    return out32[575-32*i -: 32];
  endfunction

  function automatic logic [63:0] w64(input int i);
    return out64[1087-64*i -: 64];
  endfunction

  task automatic idle32(input string tag);
    chk({tag, "_out0"}, {63'b0, |out32}, 64'd0);
    chk({tag, "_ordy"}, {63'b0, ordy32}, 64'd0);
    chk({tag, "_bf"}, {63'b0, bf32}, 64'd0);
    chk({tag, "_lb"}, {63'b0, lb32}, 64'd0);
  endtask

  task automatic run_hello(input string tag);
    int n;
    send32(32'h48656C6C, 1'b0, 2'd0);
    send32(32'h6F2C2077, 1'b0, 2'd0);
    chk({tag, "_bf_fill"}, {63'b0, bf32}, 64'd0);
    send32(32'h6F726C64, 1'b0, 2'd0);
    send32(32'h21202020, 1'b1, 2'd1);
    chk({tag, "_bf_pad"}, {63'b0, bf32}, 64'd1);
    wait32(n);
    chk({tag, "_pad_cycles"}, 64'(n), 64'd14);
    chk({tag, "_w0"}, {32'b0, w32(0)}, 64'h48656C6C);
    chk({tag, "_w3"}, {32'b0, w32(3)}, 64'h21010000);
    chk({tag, "_w4"}, {32'b0, w32(4)}, 64'h0);
    chk({tag, "_w17"}, {32'b0, w32(17)}, 64'h80);
    chk({tag, "_lb"}, {63'b0, lb32}, 64'd1);
    ack32_pulse();
    chk({tag, "_done_ordy"}, {63'b0, ordy32}, 64'd0);
    chk({tag, "_done_bf"}, {63'b0, bf32}, 64'd1);
    clear32();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    clr32 = 0; rdy32 = 0; last32 = 0; ack32 = 0; in32 = '0; bn32 = '0;
    clr64 = 0; rdy64 = 0; last64 = 0; ack64 = 0; in64 = '0; bn64 = '0;
    model_reset(0);
    model_reset(1);
    #12;
    idle32("rst32");
    chk("rst64_out0", {63'b0, |out64}, 64'd0);
    chk("rst64_ordy", {63'b0, ordy64}, 64'd0);
    chk("rst64_bf", {63'b0, bf64}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc();

    // Short message padded over many zero words
    run_hello("s1");

    // Final word lands in the last slot: suffix and 0x80 share a byte
    for (int i = 0; i < 17; i++) send32(32'hA5000000 + 32'(i), 1'b0, 2'd0);
    send32(32'h78797A20, 1'b1, 2'd3);
    chk("s2_no_pad", {63'b0, ordy32}, 64'd1);
    chk("s2_w0", {32'b0, w32(0)}, 64'hA5000000);
    chk("s2_w17", {32'b0, w32(17)}, 64'h78797A81);
    chk("s2_lb", {63'b0, lb32}, 64'd1);
    ack32_pulse();
    clear32();

    // Full block, stalled permutation, then a pure padding block
    for (int i = 0; i < 18; i++) send32(32'h3C000000 + 32'(i * 257), 1'b0, 2'd0);
    chk("s3_ordy", {63'b0, ordy32}, 64'd1);
    chk("s3_lb", {63'b0, lb32}, 64'd0);
    for (int s = 0; s < 5; s++) begin
      chk("s3_stall_bf", {63'b0, bf32}, 64'd1);
      send32(32'hDEADBEEF, 1'b1, 2'd2);
    end
    chk("s3_stall_ordy", {63'b0, ordy32}, 64'd1);
    chk("s3_stall_w0", {32'b0, w32(0)}, 64'h3C000000);
    ack32_pulse();
    idle32("s3_after_ack");
    send32(32'h0, 1'b1, 2'd0);
    wait32(n);
    chk("s3_pad_cycles", 64'(n), 64'd17);
    chk("s3_w0", {32'b0, w32(0)}, 64'h01000000);
    chk("s3_w17", {32'b0, w32(17)}, 64'h80);
    chk("s3_lb2", {63'b0, lb32}, 64'd1);
    ack32_pulse();
    clear32();

    // 64-bit words, SHA-3 suffix
    send64(64'h6162632000000000, 1'b1, 3'd3);
    wait64(n);
    chk("s4_pad_cycles", 64'(n), 64'd16);
    chk("s4_w0", w64(0), 64'h6162630600000000);
    chk("s4_w16", w64(16), 64'h80);
    chk("s4_lb", {63'b0, lb64}, 64'd1);
    ack64 = 1'b1; cyc(); ack64 = 1'b0;
    chk("s4_done_bf", {63'b0, bf64}, 64'd1);
    clr64 = 1'b1; cyc(); clr64 = 1'b0; model_reset(1);
    chk("s4_clr_bf", {63'b0, bf64}, 64'd0);

    // clear mid-PAD, then clear together with f_ack in FULL
    send32(32'h48656C6C, 1'b1, 2'd2);
    cyc(); cyc(); cyc();
    clear32();
    idle32("s5_clr_pad");
    send32(32'h11223344, 1'b1, 2'd0);
    wait32(n);
    chk("s5_pad_cycles", 64'(n), 64'd17);
    clr32 = 1'b1; ack32 = 1'b1;
    cyc();
    clr32 = 1'b0; ack32 = 1'b0;
    model_reset(0);
    idle32("s5_clr_ack");

    // Asynchronous reset mid-FILL
    send32(32'hCAFEF00D, 1'b0, 2'd0);
    send32(32'h12345678, 1'b0, 2'd0);
    #1 reset_n = 1'b0;
    #1 idle32("s6_async");
    #1 reset_n = 1'b1;
    model_reset(0);
    cyc();
    run_hello("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
